// File: rtl/ws2812b_tx.sv
// WS2812B single-wire NRZ transmitter for a ring of N_LEDS LEDs.
// One frame per accepted start: the LED mask and intensity are captured. The
// bits go out as G, R, B per LED, with LED 0 first and each byte MSB first.
// The line is then held low for the latch period.
module ws2812b_tx #(
  parameter int N_LEDS = 12,
  parameter int T_BIT  = 50,
  parameter int T0H    = 16,
  parameter int T1H    = 32,
  parameter int T_RES  = 12000
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [N_LEDS-1:0] led_mask,
  input  logic [7:0]        intensity,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  // Counter widths. Each LED counter has room for one value past its
  // terminal count, so index arithmetic never wraps.
  localparam int CYC_W = $clog2(T_BIT);
  localparam int LED_W = $clog2(N_LEDS + 1);
  localparam int RES_W = $clog2(T_RES + 1);
  localparam int PAD_W = 1 << LED_W;

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
  localparam logic [LED_W-1:0] LAST_LED = LED_W'(N_LEDS - 1);
  localparam logic [RES_W-1:0] LAST_RES = RES_W'(T_RES - 1);
  localparam logic [4:0]       LAST_SUB = 5'd23;

  // Reject timing parameters that cannot form a valid bit waveform.
  generate
    if (!(N_LEDS >= 1 && T0H > 0 && T1H > T0H && T_BIT > T1H && T_RES >= 1)) begin : g_param_check
      $error("ws2812b_tx: require N_LEDS>=1, 0<T0H<T1H<T_BIT, T_RES>=1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t              state_reg, state_next;
  logic [CYC_W-1:0]    cyc_reg, cyc_next;    // cycle within the current bit
  logic [4:0]          sub_reg, sub_next;    // bit within the current LED, 0..23
  logic [LED_W-1:0]    led_reg, led_next;    // LED index
  logic [RES_W-1:0]    lat_reg, lat_next;    // latch-period cycle counter
  logic [N_LEDS-1:0]   mask_reg, mask_next;  // frame snapshot of led_mask
  logic [7:0]          int_reg, int_next;    // frame snapshot of intensity
  logic                dout_reg, dout_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  // Mask zero-padded to a power of two so any led index is in range.
  logic [PAD_W-1:0]    mask_pad;
  logic                bit_next;
  logic [CYC_W-1:0]    thigh_next;

  assign mask_pad = PAD_W'(mask_next);
  assign dout     = dout_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  // State and datapath registers; reset returns everything to idle with no done.
  always_ff @(posedge clk) begin
    if (res) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      sub_reg   <= '0;
      led_reg   <= '0;
      lat_reg   <= '0;
      mask_reg  <= '0;
      int_reg   <= '0;
      dout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      sub_reg   <= sub_next;
      led_reg   <= led_next;
      lat_reg   <= lat_next;
      mask_reg  <= mask_next;
      int_reg   <= int_next;
      dout_reg  <= dout_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic. The dout value is computed for the cycle that the
  // registers are about to enter, so the line comes straight from a flop.
  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    sub_next   = sub_reg;
    led_next   = led_reg;
    lat_next   = lat_reg;
    mask_next  = mask_reg;
    int_next   = int_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    dout_next  = 1'b0;
    bit_next   = 1'b0;
    thigh_next = T0H_C;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          state_next = SEND;
          mask_next  = led_mask;
          int_next   = intensity;
          cyc_next   = '0;
          sub_next   = '0;
          led_next   = '0;
          busy_next  = 1'b1;
        end
      end
      SEND: begin
        busy_next = 1'b1;
        if (cyc_reg == LAST_CYC) begin
          cyc_next = '0;
          if (sub_reg == LAST_SUB) begin
            sub_next = '0;
            if (led_reg == LAST_LED) begin
              state_next = LATCH;
              led_next   = '0;
              lat_next   = '0;
            end else begin
              led_next = led_reg + 1'b1;
            end
          end else begin
            sub_next = sub_reg + 1'b1;
          end
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end
      LATCH: begin
        busy_next = 1'b1;
        if (lat_reg == LAST_RES) begin
          state_next = IDLE;
          lat_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          lat_next = lat_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // Each 8-bit channel is sent MSB first, and sub[2:0] is the position
    // within that channel. An unlit LED sends zeros.
    if (state_next == SEND) begin
      bit_next   = mask_pad[led_next] & int_next[~sub_next[2:0]];
      thigh_next = bit_next ? T1H_C : T0H_C;
      dout_next  = (cyc_next < thigh_next);
    end
  end

endmodule

// File: tb/tb_ws2812b_tx.sv
// Scoreboard bench for ws2812b_tx: stimulus queues expected frames, and a
// monitor measures every bit's high time, the latch period, busy and done.
`timescale 1ns/1ps
module tb_ws2812b_tx;

  localparam int N_LEDS = 12;
  localparam int T_BIT  = 50;
  localparam int T0H    = 16;
  localparam int T1H    = 32;
  localparam int T_RES  = 12000;
  localparam int N_BITS = N_LEDS * 24;
  localparam int FRAME  = N_BITS * T_BIT + T_RES;   // 26400

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic [11:0] led_mask = '0;
  logic [7:0]  intensity = '0;
  logic        dout, busy, done;

  ws2812b_tx #(
    .N_LEDS(N_LEDS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RES(T_RES)
  ) dut (
    .clk(clk), .res(res), .start(start), .led_mask(led_mask),
    .intensity(intensity), .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] mask;
    logic [7:0]  inten;
    bit          abort;   // frame is expected to be cut short by reset
    bit          b2b;     // frame is expected to start right after the previous done
  } frame_t;

  frame_t exp_q[$];
  int n_tests    = 0;
  int n_fail     = 0;
  int frames_end = 0;
  int done_cnt   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: a lit LED sends intensity on G, R and B, MSB first.
  function automatic int exp_high(input logic [11:0] m, input logic [7:0] v, input int b);
    int   led;
    int   pos;
    logic bv;
    led = b / 24;
    pos = b % 24;
    bv  = m[led] & v[7 - (pos % 8)];
    return bv ? T1H : T0H;
  endfunction

  always @(negedge clk) if (done) done_cnt++;

  // Monitor: frame start is the first sample with busy high.
  initial begin : monitor
    frame_t e;
    int     gap, lead, blen, lowbad;
    bit     seen_low, shape_ok, aborted;
    gap = 0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        gap++;
        continue;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        e = '{12'h000, 8'h00, 1'b0, 1'b0};
      end else begin
        e = exp_q.pop_front();
      end
      if (e.b2b) check("b2b_idle_gap", gap, 0);
      blen    = 0;
      aborted = 1'b0;
      for (int b = 0; b < N_BITS && !aborted; b++) begin
        lead     = 0;
        seen_low = 1'b0;
        shape_ok = 1'b1;
        for (int c = 0; c < T_BIT; c++) begin
          if (b > 0 || c > 0) @(negedge clk);
          if (!busy) begin
            aborted = 1'b1;
            break;
          end
          blen++;
          if (dout) begin
            if (seen_low) shape_ok = 1'b0;
            else lead++;
          end else begin
            seen_low = 1'b1;
          end
        end
        // A broken waveform shape (high after low) is reported as 1000+lead.
        if (!aborted)
          check($sformatf("bit%0d_high", b), shape_ok ? lead : 1000 + lead,
                exp_high(e.mask, e.inten, b));
      end
      if (!aborted) begin
        lowbad = 0;
        for (int i = 0; i < T_RES; i++) begin
          @(negedge clk);
          if (!busy) begin
            aborted = 1'b1;
            break;
          end
          blen++;
          if (dout) lowbad++;
        end
      end
      if (!aborted) begin
        check("latch_high_cycles", lowbad, 0);
        @(negedge clk);
        check("busy_cycles", blen, FRAME);
        check("busy_done_at_end", {busy, done}, 2'b01);
        check("dout_idle", dout, 0);
        $display("[TB] frame mask=%h int=%h busy_cycles=%0d complete", e.mask, e.inten, blen);
      end else begin
        $display("[TB] frame mask=%h int=%h cut short after %0d busy cycles", e.mask, e.inten, blen);
      end
      check("frame_abort_state", aborted, e.abort);
      frames_end++;
      gap = 0;
    end
  end

  task automatic send(input logic [11:0] m, input logic [7:0] v, input bit ab);
    exp_q.push_back('{m, v, ab, 1'b0});
    led_mask  = m;
    intensity = v;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_end(input int n);
    for (int i = 0; i < 2 * FRAME && frames_end < n; i++) @(negedge clk);
    check("frame_end_reached", frames_end >= n, 1);
  endtask

  initial begin : stim
    int base;
    // Reset held for 3 cycles while start is high: nothing may start.
    res   = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_dout", dout, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    res   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // LED0 lit at intensity 1. At bit 50 the inputs change and start
    // is pulsed; the frame content must not change and no frame may be queued.
    send(12'h001, 8'h01, 1'b0);
    repeat (50 * T_BIT - 1) @(negedge clk);
    led_mask  = 12'hFFF;
    intensity = 8'hFF;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_end(1);
    repeat (200) @(negedge clk);
    check("no_queued_frame_busy", busy, 0);
    check("no_queued_frame_count", frames_end, 1);

    // Reset during bit 100: outputs drop at that edge and no done follows.
    send(12'hFFF, 8'hAA, 1'b1);
    repeat (100 * T_BIT + 10 - 1) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    check("midrst_dout", dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    base = done_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt, base);
    check("midrst_frame_seen", frames_end, 2);

    // Start held high: an all-dark frame, then a back-to-back frame
    // accepted in the done cycle.
    exp_q.push_back('{12'h000, 8'h5A, 1'b0, 1'b0});
    exp_q.push_back('{12'h0F0, 8'h3C, 1'b0, 1'b1});
    led_mask  = 12'h000;
    intensity = 8'h5A;
    start     = 1'b1;
    @(negedge clk);
    led_mask  = 12'h0F0;    // snapshot of the first frame is already taken
    intensity = 8'h3C;
    wait_end(3);
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", busy, 1);
    wait_end(4);
    repeat (100) @(negedge clk);
    check("idle_after_b2b", busy, 0);

    check("done_pulses", done_cnt, 3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
